sigma_16p_expand: RTL and testbench
===================================

Name: sigma_16p_expand

Overview:
Interpolating counterpart of the 16-point accumulator. It takes 12-bit block sums with a one-cycle valid strobe, averages each sum by 16, and replays that average as 16 sign-magnitude 8-bit samples, each with a sample strobe at a fixed clock-divided rate. It drives sample-rate consumers, including a downstream 16-point accumulator for loopback checks.

Parameters:
DIV, 4, clocks per output sample period; legal range 2..256.

Ports:
clk  input  1  system clock, rising edge.
res  input  1  asynchronous, active-high reset.
sum_in  input  12  block sum, two's complement.
sum_valid  input  1  one-cycle strobe qualifying sum_in.
data_out  output  8  sample, sign-magnitude: bit7 = sign, bits[6:0] = magnitude.
syn_out  output  1  one-cycle strobe marking each new data_out.
blk_done  output  1  one-cycle pulse coincident with the 16th syn_out of a block.
busy  output  1  high while a block is replaying.
ovf  output  1  one-cycle pulse when a sum is dropped.

Behaviour:
- Reset (res high, asynchronous):
  - Outputs: data_out=0, syn_out=0, blk_done=0, busy=0, ovf=0.
  - State: state=IDLE, pending buffer empty, counters 0.
  - Reset mid-block aborts the block immediately and discards the pending sum.
- Arithmetic, computed once when a sum is loaded into the active register:
  - avg = sum_in arithmetically shifted right by 4 (floor); range -128..127.
  - avg >= 0: data_out = {0, avg[6:0]}.
  - avg < 0: data_out = {1, (-avg)[6:0]}.
  - avg = -128 saturates to magnitude 127 (0xFF).
  - Minus zero is never produced.
- States:
  - IDLE: busy=0. The edge that samples sum_valid=1 loads the active register, sets data_out, sets syn_out=1 for the next cycle, sets the sample count to 1 and the divider to 0, and goes to PLAY. Latency from sum_valid edge to syn_out high: 1 cycle, registered.
  - PLAY: busy=1.
    - The divider counts 0..DIV-1.
    - On each wrap while the sample count is < 16: assert syn_out for one cycle, count+1. data_out holds the same value across all 16 samples of a block.
    - The sample period is exactly DIV clocks between syn_out rises; a block spans 16*DIV clocks.
    - The 16th syn_out also asserts blk_done.
- Block end: at the divider wrap after the 16th sample (the slot where a 17th strobe would fall):
  - If the pending buffer is full: load the pending sum, strobe syn_out as sample 1 of the new block, and stay in PLAY. No gap between blocks.
  - Else if sum_valid=1 in that same cycle: load it directly, same as above.
  - Else: go to IDLE with busy=0. data_out holds its last value and syn_out stays 0.
- Pending buffer (one entry):
  - sum_valid in PLAY with the buffer empty: store the sum.
  - sum_valid with the buffer full: drop the new sum, pulse ovf, and keep the buffered sum.
  - Simultaneous pending load and new sum_valid at block end: the pending sum is consumed and the new one is stored into the freed buffer, with no ovf.
- syn_out, blk_done and ovf are single-cycle pulses and never stretch.

Test Plan:
- Reset, idle: res=1 then 0, no sum_valid for 100 clk -> all outputs 0, busy 0.
- Positive full scale, DIV=4: sum_in=0x7F0 pulsed once -> syn_out 1 cycle after the strobe, then every 4 clk, 16 pulses, data_out=0x7F throughout; blk_done on pulse 16; busy falls 4 clk later.
- Rounding and sign:
  - sum_in=0x00F -> 0x00.
  - sum_in=0xFFF -> avg -1 -> 0x81.
  - sum_in=0xFF0 -> 0x81.
  - sum_in=0x800 -> saturates to 0xFF.
  - sum_in=0x010 -> 0x01.
- Back-to-back blocks: second sum 0x100 delivered mid-block of first 0x7F0 -> 32 syn_out pulses with uniform 4-clk spacing across the boundary; data_out 0x7F for 16 then 0x10 for 16; no ovf.
- Overflow: three sums (0x100, 0x200, 0x300) on consecutive clocks from IDLE -> blocks 0x10 then 0x20 play; the third sum is dropped and ovf pulses once on the 0x300 strobe cycle.
- Reset mid-block: res asserted after syn_out pulse 7 with a sum pending -> outputs clear immediately; after release no syn_out occurs until a new sum_valid arrives.

Source files
------------

// File: rtl/sigma_16p_expand_if.sv
`default_nettype none
// ============================================================================
//  Module   : sigma_16p_expand_if
//  Brief    : Sum-in / sample-out bundle for the 16-point interpolating expander.
//  Revision : 1.0  initial release
// ============================================================================
interface sigma_16p_expand_if;
  logic [11:0] sum_in;
  logic        sum_valid;
  logic [7:0]  data_out;
  logic        syn_out;
  logic        blk_done;
  logic        busy;
  logic        ovf;

  // master supplies block sums and consumes samples; slave is the expander
  modport master (
    output sum_in, sum_valid,
    input  data_out, syn_out, blk_done, busy, ovf
  );

  modport slave (
    input  sum_in, sum_valid,
    output data_out, syn_out, blk_done, busy, ovf
  );
endinterface
`default_nettype wire

// File: rtl/sigma_16p_expand.sv
`default_nettype none
// ============================================================================
//  Module   : sigma_16p_expand
//  Brief    : Replays each 12-bit block sum as 16 sign-magnitude averages,
//             one per DIV clocks, with a one-entry pending buffer.
//  Revision : 1.0  initial release
// ============================================================================
module sigma_16p_expand #(
  parameter int DIV = 4
) (
  input wire                clk,
  input wire                res,
  sigma_16p_expand_if.slave bus
);

  localparam int                 c_DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_data;
  logic                 r_syn;
  logic                 r_done;
  logic [4:0]           r_cnt;
  logic [c_DIV_W-1:0]   r_div;
  logic [11:0]          r_pend;
  logic                 r_pend_full;

  logic                 w_wrap;
  logic                 w_blk_end;
  logic                 w_load;
  logic                 w_load_pend;
  logic                 w_pend_set;
  logic                 w_pend_clr;
  logic                 w_ovf;
  logic                 w_syn_nxt;
  logic                 w_done_nxt;
  logic [4:0]           w_cnt_nxt;
  logic [c_DIV_W-1:0]   w_div_nxt;

  // floor(sum/16) is simply bits [11:4]; -128 has no 7-bit magnitude so it clamps
  function automatic logic [7:0] to_sm(input logic [11:0] s);
    logic [7:0] a;
    logic [7:0] n;
    a = s[11:4];
    n = 8'd0 - a;
    if (!a[7])
      to_sm = {1'b0, a[6:0]};
    else if (a == 8'h80)
      to_sm = 8'hFF;
    else
      to_sm = {1'b1, n[6:0]};
  endfunction

  assign w_wrap    = (r_div == c_DIV_LAST);
  assign w_blk_end = (r_state == ST_PLAY) && w_wrap && (r_cnt == 5'd16);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_pend = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_ovf       = 1'b0;
    w_syn_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    case (r_state)
      ST_IDLE: begin
        if (bus.sum_valid) begin
          w_load      = 1'b1;
          w_syn_nxt   = 1'b1;
          w_cnt_nxt   = 5'd1;
          w_div_nxt   = '0;
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        w_div_nxt = w_wrap ? '0 : r_div + c_DIV_ONE;
        if (w_blk_end) begin
          // the 17th slot doubles as sample 1 of the next block when one is ready
          if (r_pend_full) begin
            w_load      = 1'b1;
            w_load_pend = 1'b1;
            w_syn_nxt   = 1'b1;
            w_cnt_nxt   = 5'd1;
            w_pend_set  = bus.sum_valid;
            w_pend_clr  = !bus.sum_valid;
          end else if (bus.sum_valid) begin
            w_load    = 1'b1;
            w_syn_nxt = 1'b1;
            w_cnt_nxt = 5'd1;
          end else begin
            w_cnt_nxt   = 5'd0;
            w_div_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          if (w_wrap && (r_cnt < 5'd16)) begin
            w_syn_nxt  = 1'b1;
            w_done_nxt = (r_cnt == 5'd15);
            w_cnt_nxt  = r_cnt + 5'd1;
          end
          if (bus.sum_valid) begin
            w_ovf      = r_pend_full;
            w_pend_set = !r_pend_full;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_data      <= 8'd0;
      r_syn       <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= 5'd0;
      r_div       <= '0;
      r_pend      <= 12'd0;
      r_pend_full <= 1'b0;
    end else begin
      r_syn  <= w_syn_nxt;
      r_done <= w_done_nxt;
      r_cnt  <= w_cnt_nxt;
      r_div  <= w_div_nxt;
      if (w_load)
        r_data <= to_sm(w_load_pend ? r_pend : bus.sum_in);
      if (w_pend_set) begin
        r_pend      <= bus.sum_in;
        r_pend_full <= 1'b1;
      end else if (w_pend_clr) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  assign bus.data_out = r_data;
  assign bus.syn_out  = r_syn;
  assign bus.blk_done = r_done;
  assign bus.busy     = (r_state == ST_PLAY);
  assign bus.ovf      = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sigma_16p_expand.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sigma_16p_expand
//  Brief    : Directed bench with a block-schedule reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sigma_16p_expand;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  sigma_16p_expand_if bus ();
  sigma_16p_expand #(.DIV(DIV)) dut (.clk(clk), .res(res), .bus(bus));

  always #5 clk = ~clk;

  // reference model state: time-stamped block schedule
  int          c       = 0;
  bit          m_act   = 1'b0;
  int          m_start = 0;
  logic [7:0]  m_data  = 8'd0;
  logic [11:0] pend[$];
  int          n_syn   = 0;
  int          n_ovf   = 0;
  int          n_done  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sm_of(input logic [11:0] s);
    int v, avg, mag;
    v   = int'($signed(s));
    avg = (v >= 0) ? v / 16 : -((-v + 15) / 16);
    mag = (avg < 0) ? -avg : avg;
    if (mag > 127) mag = 127;
    return (avg < 0) ? (8'h80 | 8'(mag)) : 8'(mag);
  endfunction

  always @(posedge clk or posedge res) begin : p_model
    if (res) begin
      c      = 0;
      m_act  = 1'b0;
      m_data = 8'd0;
      pend.delete();
    end else begin
      c = c + 1;
      if (!m_act) begin
        if (bus.sum_valid) begin
          m_act   = 1'b1;
          m_start = c;
          m_data  = sm_of(bus.sum_in);
        end
      end else if (c == m_start + 16 * DIV) begin
        if (pend.size() != 0) begin
          m_data  = sm_of(pend.pop_front());
          m_start = c;
          if (bus.sum_valid) pend.push_back(bus.sum_in);
        end else if (bus.sum_valid) begin
          m_data  = sm_of(bus.sum_in);
          m_start = c;
        end else begin
          m_act = 1'b0;
        end
      end else if (bus.sum_valid && pend.size() == 0) begin
        pend.push_back(bus.sum_in);
      end
    end
  end

  always @(negedge clk) begin : p_cmp
    int   off;
    logic e_syn, e_done, e_ovf;
    off    = c - m_start;
    e_syn  = m_act && (off % DIV == 0) && (off < 16 * DIV);
    e_done = m_act && (off == 15 * DIV);
    e_ovf  = !res && m_act && (c + 1 != m_start + 16 * DIV) && bus.sum_valid && (pend.size() == 1);
    chk("data_out", bus.data_out, m_data);
    chk("syn_out", {7'd0, bus.syn_out}, {7'd0, e_syn});
    chk("blk_done", {7'd0, bus.blk_done}, {7'd0, e_done});
    chk("busy", {7'd0, bus.busy}, {7'd0, m_act});
    chk("ovf", {7'd0, bus.ovf}, {7'd0, e_ovf});
    if (bus.syn_out === 1'b1)  n_syn  = n_syn + 1;
    if (bus.ovf === 1'b1)      n_ovf  = n_ovf + 1;
    if (bus.blk_done === 1'b1) n_done = n_done + 1;
  end

  task automatic send(input logic [11:0] v);
    @(posedge clk); #1;
    bus.sum_in    = v;
    bus.sum_valid = 1'b1;
    @(posedge clk); #1;
    bus.sum_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [11:0] rt_in [5] = '{12'h00F, 12'hFFF, 12'hFF0, 12'h800, 12'h010};
  logic [7:0]  rt_exp[5] = '{8'h00, 8'h81, 8'h81, 8'hFF, 8'h01};

  initial begin : p_stim
    int s0, o0, d0;
    bit hit;
    bus.sum_in    = 12'd0;
    bus.sum_valid = 1'b0;

    // model pinned to hand-computed conversions
    chk("model_7f0", sm_of(12'h7F0), 8'h7F);
    chk("model_100", sm_of(12'h100), 8'h10);
    for (int i = 0; i < 5; i++) chk("model_round", sm_of(rt_in[i]), rt_exp[i]);

    // reset then quiet idle
    idle(3);
    res = 1'b0;
    s0 = n_syn;
    idle(100);
    chk("idle_syn_count", 8'(n_syn - s0), 8'd0);
    chk("idle_busy", {7'd0, bus.busy}, 8'd0);

    // positive full scale
    s0 = n_syn; d0 = n_done;
    send(12'h7F0);
    @(negedge clk);
    chk("fs_first_syn", {7'd0, bus.syn_out}, 8'd1);
    chk("fs_data", bus.data_out, 8'h7F);
    idle(16 * DIV + 8);
    chk("fs_syn_count", 8'(n_syn - s0), 8'd16);
    chk("fs_done_count", 8'(n_done - d0), 8'd1);
    chk("fs_busy_end", {7'd0, bus.busy}, 8'd0);
    chk("fs_data_hold", bus.data_out, 8'h7F);

    // rounding and sign
    for (int i = 0; i < 5; i++) begin
      send(rt_in[i]);
      @(negedge clk);
      chk("round_data", bus.data_out, rt_exp[i]);
      idle(16 * DIV + 4);
    end

    // back-to-back blocks
    s0 = n_syn; o0 = n_ovf; d0 = n_done;
    send(12'h7F0);
    idle(20);
    send(12'h100);
    idle(32 * DIV + 8);
    chk("b2b_syn_count", 8'(n_syn - s0), 8'd32);
    chk("b2b_ovf_count", 8'(n_ovf - o0), 8'd0);
    chk("b2b_done_count", 8'(n_done - d0), 8'd2);
    chk("b2b_data_last", bus.data_out, 8'h10);

    // overflow: three sums on consecutive clocks
    s0 = n_syn; o0 = n_ovf;
    @(posedge clk); #1; bus.sum_in = 12'h100; bus.sum_valid = 1'b1;
    @(posedge clk); #1; bus.sum_in = 12'h200;
    @(posedge clk); #1; bus.sum_in = 12'h300;
    @(negedge clk);
    chk("ovf_on_third", {7'd0, bus.ovf}, 8'd1);
    @(posedge clk); #1; bus.sum_valid = 1'b0;
    idle(32 * DIV + 8);
    chk("ovf_count", 8'(n_ovf - o0), 8'd1);
    chk("ovf_syn_count", 8'(n_syn - s0), 8'd32);
    chk("ovf_data_last", bus.data_out, 8'h20);

    // reset mid-block with a pending sum
    s0 = n_syn;
    send(12'h7F0);
    idle(2 * DIV);
    send(12'h300);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (n_syn - s0 >= 7) hit = 1'b1;
    end
    chk("rst_reached_pulse7", {7'd0, hit}, 8'd1);
    #2 res = 1'b1;
    #1;
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_syn", {7'd0, bus.syn_out}, 8'd0);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_done", {7'd0, bus.blk_done}, 8'd0);
    chk("rst_ovf", {7'd0, bus.ovf}, 8'd0);
    idle(2);
    res = 1'b0;
    s0 = n_syn;
    idle(100);
    chk("rst_no_syn", 8'(n_syn - s0), 8'd0);
    send(12'h010);
    @(negedge clk);
    chk("rst_new_data", bus.data_out, 8'h01);
    idle(16 * DIV + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
